memory_bus_decoder: RTL
=======================

// Module: memory_bus_decoder
// PURPOSE
//  Address decoder between the memory controller's flat bus and its targets: the RAM
//  and a small memory-mapped I/O register file (LEDs, green LEDs, hex display,
//  cycle counter, bus-error status). Single clock domain, one-cycle read latency.
//  Gives software control of board I/O previously hard-wired to debug signals.
// PARAMETERS
//  RAM_ADDR_WIDTH  14        RAM word-address bits passed to RAM (AddressBus[RAM_ADDR_WIDTH-1:0])
//  IO_REGION       8'hF0     AddressBus[31:24] value selecting the I/O register file
//  UNMAPPED_DATA   32'h0     read data returned for unmapped addresses
// PORTS
//  CoreClock      in   1   sole clock; all logic on posedge
//  Reset          in   1   synchronous, active-high reset
//  AddressBus     in   32  address from memory controller, valid every cycle
//  DataWriteBus   in   32  write data from memory controller
//  WriteAssert    in   1   write strobe, one write per cycle while high
//  DataReadBus    out  32  read data for the address presented on the previous cycle
//  RamAddress     out  RAM_ADDR_WIDTH  RAM address (combinational pass-through)
//  RamWriteData   out  32  RAM write data (pass-through of DataWriteBus)
//  RamWriteEnable out  1   WriteAssert gated by RAM region hit
//  RamReadData    in   32  RAM synchronous read data (1-cycle latency)
//  LedOut         out  10  LED register
//  LedGreenOut    out  8   green LED register
//  HexOut         out  16  hex display register
//  BusError       out  1   sticky unmapped-access flag (STATUS[0])
// BEHAVIOUR
//  Decode: RAM hit = AddressBus[31:24]==0 and AddressBus[23:RAM_ADDR_WIDTH]==0;
//   IO hit = AddressBus[31:24]==IO_REGION and AddressBus[23:4]==0; else unmapped.
//  IO map (AddressBus[3:0]): 0 LED rw [9:0]; 1 LEDG rw [7:0]; 2 HEX rw [15:0];
//   3 CYCLE rw 32b; 4 STATUS: bit0 BusError, write bit0=1 clears; 5 ERRADDR ro 32b;
//   6..F unmapped (read UNMAPPED_DATA, write ignored, sets BusError).
//  Unused upper bits of narrow registers read 0; writes take low bits only.
//  Writes: registers update on the clock edge where WriteAssert=1 and the address hits.
//  Reads: region select and IO read value registered each cycle; DataReadBus on
//   cycle N+1 = RamReadData if cycle-N address hit RAM, registered IO value if IO,
//   UNMAPPED_DATA otherwise. Read-after-write same register: cycle-N write is
//   visible to a read issued on cycle N+1 (old value if read issued on cycle N).
//  CYCLE: +1 every cycle, wraps FFFF_FFFF->0; a write loads DataWriteBus that
//   cycle (write wins over increment; next cycle shows loaded+1).
//  BusError: set on any cycle whose address is unmapped (read or write); on the
//   0->1 transition ERRADDR captures AddressBus; later errors do not overwrite.
//   Set and clear-write on same cycle: set wins.
//  RamWriteEnable = WriteAssert & RAM hit; never asserted for IO/unmapped.
//  Reset (sync, any cycle incl. mid-write): LED, LEDG, HEX, CYCLE, ERRADDR,
//   BusError, registered select/data -> 0; DataReadBus = 0 the cycle after reset.
//   A write coincident with Reset is discarded; RamWriteEnable is forced 0 during Reset.
// TESTING
//  Reset 3 cycles, release -> LedOut/HexOut/BusError=0, CYCLE reads 1 cycle later small count.
//  Write 0x3FF to F000_0000, 0xBEEF to F000_0002 -> LedOut=0x3FF, HexOut=0xBEEF next cycle; reads return same.
//  Write 0x1234 to RAM addr 0x0010, read back -> RamWriteEnable pulse 1 cycle, DataReadBus=0x1234 one cycle after read address.
//  Write FFFF_FFFE to CYCLE, read over 3 cycles -> sequence wraps through FFFF_FFFF to 0.
//  Read 0x0001_0000 then 0xF000_0007 -> BusError=1, ERRADDR=0x0001_0000; write 1 to STATUS -> BusError=0.
//  Assert Reset while WriteAssert=1 to F000_0000 -> LedOut stays 0, RamWriteEnable=0.

Source files
------------

// File: rtl/memory_bus_decoder.sv
// memory_bus_decoder: splits the memory controller's flat bus between the RAM
// and a small memory-mapped I/O register file. Register map, low address nibble:
//   0 LED (10b), 1 LEDG (8b), 2 HEX (16b), 3 CYCLE (32b free-running counter),
//   4 STATUS (bit0 sticky bus error, write 1 to clear), 5 ERRADDR (first bad address).
// Reads have one cycle of latency, matching the synchronous RAM.
module memory_bus_decoder #(
   parameter int unsigned RAM_ADDR_WIDTH = 14,
   parameter logic [7:0]  IO_REGION      = 8'hF0,
   parameter logic [31:0] UNMAPPED_DATA  = 32'h0
) (
   input  logic                      CoreClock,
   input  logic                      Reset,
   input  logic [31:0]               AddressBus,
   input  logic [31:0]               DataWriteBus,
   input  logic                      WriteAssert,
   output logic [31:0]               DataReadBus,
   output logic [RAM_ADDR_WIDTH-1:0] RamAddress,
   output logic [31:0]               RamWriteData,
   output logic                      RamWriteEnable,
   input  logic [31:0]               RamReadData,
   output logic [9:0]                LedOut,
   output logic [7:0]                LedGreenOut,
   output logic [15:0]               HexOut,
   output logic                      BusError
);

   localparam int unsigned DataWidth   = 32;
   localparam int unsigned LedWidth    = 10;
   localparam int unsigned LedgWidth   = 8;
   localparam int unsigned HexWidth    = 16;
   localparam int unsigned IndexWidth  = 4;

   localparam logic [IndexWidth-1:0] RegLed     = 4'h0;
   localparam logic [IndexWidth-1:0] RegLedg    = 4'h1;
   localparam logic [IndexWidth-1:0] RegHex     = 4'h2;
   localparam logic [IndexWidth-1:0] RegCycle   = 4'h3;
   localparam logic [IndexWidth-1:0] RegStatus  = 4'h4;
   localparam logic [IndexWidth-1:0] RegErrAddr = 4'h5;

   // Source of DataReadBus on the cycle after an access; Idle only right after reset.
   typedef enum logic [1:0] {
      SelIdle = 2'd0,
      SelRam  = 2'd1,
      SelReg  = 2'd2
   } readSelT;

   logic                   ramHit;
   logic                   ioHit;
   logic                   ioRegHit;
   logic                   unmappedHit;
   logic [IndexWidth-1:0]  ioIndex;

   logic                   writeLed;
   logic                   writeLedg;
   logic                   writeHex;
   logic                   writeCycle;
   logic                   clearError;

   logic [LedWidth-1:0]    ledReg;
   logic [LedgWidth-1:0]   ledgReg;
   logic [HexWidth-1:0]    hexReg;
   logic [DataWidth-1:0]   cycleReg;
   logic                   busErrorReg;
   logic [DataWidth-1:0]   errAddrReg;

   logic [DataWidth-1:0]   ioReadValue;
   logic [DataWidth-1:0]   regReadData;
   readSelT                readSel;

   assign ioIndex = AddressBus[IndexWidth-1:0];

   // Address decode: RAM window at the bottom of the map, register file in IO_REGION.
   always_comb begin
      ramHit      = 1'b0;
      ioHit       = 1'b0;
      ioRegHit    = 1'b0;
      unmappedHit = 1'b0;
      ramHit      = ((AddressBus >> RAM_ADDR_WIDTH) == 32'd0);
      ioHit       = (AddressBus[31:24] == IO_REGION) && (AddressBus[23:4] == 20'd0);
      ioRegHit    = ioHit && !ramHit && (ioIndex <= RegErrAddr);
      unmappedHit = !ramHit && !ioRegHit;
   end

   // Per-register write strobes; a write during reset is dropped by the reset priority below.
   always_comb begin
      writeLed   = 1'b0;
      writeLedg  = 1'b0;
      writeHex   = 1'b0;
      writeCycle = 1'b0;
      clearError = 1'b0;
      if (WriteAssert && ioRegHit) begin
         case (ioIndex)
            RegLed:    writeLed   = 1'b1;
            RegLedg:   writeLedg  = 1'b1;
            RegHex:    writeHex   = 1'b1;
            RegCycle:  writeCycle = 1'b1;
            RegStatus: clearError = DataWriteBus[0];
            default:   ;
         endcase
      end
   end

   // RAM side is a straight pass-through; the write enable is gated by decode and reset.
   assign RamAddress     = AddressBus[RAM_ADDR_WIDTH-1:0];
   assign RamWriteData   = DataWriteBus;
   assign RamWriteEnable = WriteAssert && ramHit && !Reset;

   // Board I/O registers: only the low bits of the write data are kept.
   always_ff @(posedge CoreClock) begin
      if (Reset) begin
         ledReg  <= '0;
         ledgReg <= '0;
         hexReg  <= '0;
      end else begin
         if (writeLed) begin
            ledReg <= DataWriteBus[LedWidth-1:0];
         end
         if (writeLedg) begin
            ledgReg <= DataWriteBus[LedgWidth-1:0];
         end
         if (writeHex) begin
            hexReg <= DataWriteBus[HexWidth-1:0];
         end
      end
   end

   // Free-running cycle counter; a software load takes precedence over the increment.
   always_ff @(posedge CoreClock) begin
      if (Reset) begin
         cycleReg <= '0;
      end else if (writeCycle) begin
         cycleReg <= DataWriteBus;
      end else begin
         cycleReg <= cycleReg + 32'd1;
      end
   end

   // Sticky bus error; the first offending address is latched and kept until the flag clears.
   always_ff @(posedge CoreClock) begin
      if (Reset) begin
         busErrorReg <= 1'b0;
         errAddrReg  <= '0;
      end else if (unmappedHit) begin
         busErrorReg <= 1'b1;
         if (!busErrorReg) begin
            errAddrReg <= AddressBus;
         end
      end else if (clearError) begin
         busErrorReg <= 1'b0;
      end
   end

   // Register-file read mux on the pre-write values of this cycle.
   always_comb begin
      ioReadValue = UNMAPPED_DATA;
      if (ioRegHit) begin
         case (ioIndex)
            RegLed:     ioReadValue = DataWidth'(ledReg);
            RegLedg:    ioReadValue = DataWidth'(ledgReg);
            RegHex:     ioReadValue = DataWidth'(hexReg);
            RegCycle:   ioReadValue = cycleReg;
            RegStatus:  ioReadValue = DataWidth'(busErrorReg);
            RegErrAddr: ioReadValue = errAddrReg;
            default:    ioReadValue = UNMAPPED_DATA;
         endcase
      end
   end

   // Capture the read source and the register-file value for next cycle's read data.
   always_ff @(posedge CoreClock) begin
      if (Reset) begin
         readSel     <= SelIdle;
         regReadData <= '0;
      end else begin
         readSel     <= ramHit ? SelRam : SelReg;
         regReadData <= ioReadValue;
      end
   end

   // Read data return: RAM data arrives this cycle, register data was captured last edge.
   always_comb begin
      DataReadBus = '0;
      case (readSel)
         SelRam:  DataReadBus = RamReadData;
         SelReg:  DataReadBus = regReadData;
         default: DataReadBus = '0;
      endcase
   end

   assign LedOut      = ledReg;
   assign LedGreenOut = ledgReg;
   assign HexOut      = hexReg;
   assign BusError    = busErrorReg;

endmodule
